button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Debounces WIDTH asynchronous board push-buttons/switches into clean levels.
//   Also produces single-cycle press/release strobes.
//   Counterpart of the LED driver logic: the board-input side of the user I/O.
//   Sits next to the LED blinkers in the top level, all in the clk100 domain.
// PARAMETERS
//   WIDTH            4          number of independent button channels
//   DEBOUNCE_CYCLES  1000000    consecutive stable samples to accept a change (10 ms @ 100 MHz); >= 2
//   ACTIVE_LOW       1          1: pin low = pressed; 0: pin high = pressed
// PORTS
//   clk100       in   1      100 MHz system clock; all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   btn_raw      in   WIDTH  asynchronous button pins, unsynchronised
//   btn_state    out  WIDTH  debounced level, 1 = pressed (polarity already normalised)
//   btn_press    out  WIDTH  1-cycle strobe when btn_state goes 0->1
//   btn_release  out  WIDTH  1-cycle strobe when btn_state goes 1->0
//   any_press    out  1      OR of btn_press, same cycle
// BEHAVIOUR
//   - Reset (rst=1 at a posedge):
//       sync flops <= released level; btn_state/btn_press/btn_release/any_press <= 0; counters <= 0.
//       Reset mid-count discards the count; no strobe fires.
//   - Per channel:
//       2-flop synchroniser, then polarity normalise (invert if ACTIVE_LOW) -> s.
//       s is valid 2 edges after a pin change.
//   - Counter width: $clog2(DEBOUNCE_CYCLES) bits. Counter never wraps and never exceeds DEBOUNCE_CYCLES-1.
//   - FSM per channel, 2 states:
//       STABLE: s == btn_state, cnt = 0.
//               s != btn_state -> COUNT, cnt <= 1.
//       COUNT:  s == btn_state          -> STABLE, cnt <= 0 (bounce rejected, no strobe).
//               s != btn_state, cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
//               s != btn_state, cnt == DEBOUNCE_CYCLES-1 -> btn_state <= s, cnt <= 0, strobe, -> STABLE.
//   - A change is accepted after exactly DEBOUNCE_CYCLES consecutive samples of s differing from btn_state.
//   - Latency from a clean pin edge to the btn_state edge: DEBOUNCE_CYCLES+2 clk100 edges, +/-1 for synchroniser metastability.
//   - btn_press / btn_release are registered and asserted in the same cycle btn_state updates.
//       Both are high for exactly 1 cycle.
//       They are never high together on one channel.
//   - Channels are fully independent; simultaneous strobes on several channels are allowed.
//   - A button held pressed through reset release is reported as a press DEBOUNCE_CYCLES+2 edges after rst falls.
//   - Output only ever changes on a clk100 edge; no combinational path from btn_raw to any output.
// TESTING (sim with DEBOUNCE_CYCLES=16, WIDTH=4, ACTIVE_LOW=1)
//   1. Reset with btn_raw=4'hF held 5 cycles
//        -> all outputs 0 during reset and for 40 cycles after.
//   2. btn_raw[0] 1->0 clean
//        -> btn_state[0]=1 and btn_press[0]=1 for exactly 1 cycle, 18 edges later (+/-1); any_press=1 same cycle.
//   3. btn_raw[1] toggles every 5 cycles for 200 cycles, then settles low
//        -> no strobes during the bounce; single press 18 edges after settling.
//   4. Press held on ch2, then btn_raw[2] returns to 1
//        -> btn_release[2]=1 for 1 cycle, 18 edges after the pin edge; btn_press[2] stays 0.
//   5. Ch0 and ch3 pressed in the same cycle
//        -> btn_press=4'b1001 in one cycle; any_press=1 for exactly 1 cycle.
//   6. rst pulsed at count 10 of a pending press
//        -> no strobe fires; press is reported 18 edges after rst deasserts.

Source files
------------

// File: rtl/button_debounce_if.sv
// Board push-button bundle: raw pins in, debounced levels and strobes out.
// master drives the pins, slave is the debouncer.
interface button_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_state;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;
  logic             any_press;

  modport master (
    output btn_raw,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    output btn_state,
    output btn_press,
    output btn_release,
    output any_press
  );
endinterface

// File: rtl/button_debounce.sv
// WIDTH-channel push-button debouncer in the clk100 domain.
// 2-flop sync, polarity normalise, per-channel stable/count FSM.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk100,
  input  logic              rst,
  button_debounce_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] REL_LVL =
    (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic {
    STABLE,
    COUNT
  } state_e;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] s;

  state_e           st_q  [WIDTH];
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] press_q;
  logic [WIDTH-1:0] release_q;

  // Reset to the released pin level so a held button
  // is seen as a fresh change once reset lifts.
  always_ff @(posedge clk100) begin
    if (rst) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_ff @(posedge clk100) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        st_q[i]  <= STABLE;
        cnt_q[i] <= '0;
      end
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        unique case (st_q[i])
          STABLE: begin
            if (s[i] != state_q[i]) begin
              st_q[i]  <= COUNT;
              cnt_q[i] <= CW'(1);
            end
          end
          COUNT: begin
            if (s[i] == state_q[i]) begin
              st_q[i]  <= STABLE;
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              st_q[i]      <= STABLE;
              cnt_q[i]     <= '0;
              state_q[i]   <= s[i];
              press_q[i]   <= s[i];
              release_q[i] <= ~s[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + CW'(1);
            end
          end
          default: begin
            st_q[i]  <= STABLE;
            cnt_q[i] <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_state   = state_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = |press_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (WIDTH=4, DEBOUNCE_CYCLES=16).
// Stimulus queues expected strobes; a negedge monitor pops and compares.
module tb_button_debounce;

  localparam int W   = 4;
  localparam int D   = 16;
  localparam int LAT = D + 2;

  typedef struct {
    int unsigned    cyc;
    logic [W-1:0]   press;
    logic [W-1:0]   rel;
    logic [W-1:0]   state;
  } exp_t;

  logic clk100 = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  logic [W-1:0] exp_state;

  button_debounce_if #(.WIDTH(W)) bus ();

  button_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(1)
  ) dut (
    .clk100(clk100),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  // Any strobe (or any_press) must match the head of the queue.
  // RTL sim has no metastability, so the latency is exact.
  always @(negedge clk100) begin
    exp_t e;
    if ((bus.btn_press | bus.btn_release) != 0 || bus.any_press) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected cyc=%0d press=%b release=%b any=%b",
                 cyc, bus.btn_press, bus.btn_release, bus.any_press);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || bus.btn_press != e.press ||
            bus.btn_release != e.rel || bus.btn_state != e.state ||
            bus.any_press != (|e.press)) begin
          failures++;
          $display({"FAIL strobe cyc=%0d/%0d press=%b/%b release=%b/%b",
                    " state=%b/%b any=%b/%b (got/want)"},
                   cyc, e.cyc, bus.btn_press, e.press,
                   bus.btn_release, e.rel, bus.btn_state, e.state,
                   bus.any_press, |e.press);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({bus.btn_state, bus.btn_press, bus.btn_release, bus.any_press} !== '0) begin
      failures++;
      $display("FAIL %s cyc=%0d state=%b press=%b release=%b any=%b want all 0",
               name, cyc, bus.btn_state, bus.btn_press, bus.btn_release,
               bus.any_press);
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic set_pins(input logic [W-1:0] v);
    logic [W-1:0] p;
    @(posedge clk100);
    #1;
    bus.btn_raw = v;
    p = ~v;
    if (p != exp_state)
      q.push_back('{cyc + LAT, p & ~exp_state, ~p & exp_state, p});
    exp_state = p;
  endtask

  task automatic settle();
    repeat (LAT + 6) @(posedge clk100);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.btn_raw = 4'hF;
    exp_state = '0;

    // 1: reset, then quiet outputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk100);
      check_zero("reset");
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk100);
      check_zero("post_reset");
    end

    // 2: clean press on ch0
    set_pins(4'b1110);
    settle();
    check("t2_state", bus.btn_state, exp_state);

    // 3: ch1 bounces faster than the debounce window
    for (int i = 0; i < 40; i++) begin
      repeat (5) @(posedge clk100);
      #1;
      bus.btn_raw[1] = ~bus.btn_raw[1];
    end
    set_pins(4'b1100);
    settle();
    check("t3_state", bus.btn_state, exp_state);

    // 4: ch2 press then release
    set_pins(4'b1000);
    settle();
    set_pins(4'b1100);
    settle();
    check("t4_state", bus.btn_state, exp_state);

    // 5: ch0 released, then ch0 and ch3 pressed together
    set_pins(4'b1101);
    settle();
    set_pins(4'b0100);
    settle();
    check("t5_state", bus.btn_state, exp_state);

    // 6: reset at count 10 of a pending ch2 press
    @(posedge clk100);
    #1;
    bus.btn_raw = 4'b0000;
    repeat (12) @(posedge clk100);
    #1;
    rst = 1'b1;
    @(posedge clk100);
    #1;
    rst = 1'b0;
    exp_state = '0;
    @(negedge clk100);
    check_zero("t6_in_reset");
    q.push_back('{cyc + LAT, 4'hF, 4'h0, 4'hF});
    exp_state = 4'hF;
    repeat (LAT + 10) @(posedge clk100);
    check("t6_state", bus.btn_state, exp_state);

    @(negedge clk100);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes pending=%0d want 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
